ntt_round_ctrl: RTL
===================

NTT_ROUND_CTRL -- requirements
Module: ntt_round_ctrl

Interface
REQ-001 SHALL have parameters: PIPE_DEPTH, default 5, address-pipeline drain cycles; CNT_MAX, default 63, last butterfly index per layer; ROUNDS, default 4, layer count.
REQ-002 SHALL have ports: clk  input  1  sole clock, rising edge.
REQ-003 SHALL have ports: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports: start  input  1  request one transform; sampled only in IDLE.
REQ-005 SHALL have ports: mode_in  input  3  0 = forward NTT, 1 = inverse NTT; other codes are rejected.
REQ-006 SHALL have ports: stall  input  1  memory back-pressure; freezes RUN.
REQ-007 SHALL have ports: rnd_valid  input  1 and rnd_data  input  9, random mask source.
REQ-008 SHALL have ports: rnd_ready  output  1  mask-accept strobe.
REQ-009 SHALL have ports: mode  output  3  registered copy of mode_in, held for the whole transform.
REQ-010 SHALL have ports: addr_rst  output  1  active-high clear to the address unit; 1 cycle.
REQ-011 SHALL have ports: en  output  1  address-advance strobe.
REQ-012 SHALL have ports: zeta_new  output  9  current-layer mask.
REQ-013 SHALL have ports: zeta_old  output  9  previous-layer mask.
REQ-014 SHALL have ports: round  output  2, cnt  output  6, busy  output  1, done  output  1, err  output  1.

Function
REQ-015 FSM states SHALL be IDLE, CLR, LOAD, RUN, DRAIN, FIN.
REQ-016 IDLE: start=1 with a legal mode_in SHALL latch mode and go to CLR; start=1 with an illegal code SHALL pulse err for 1 cycle and stay in IDLE.
REQ-017 CLR SHALL assert addr_rst for exactly 1 cycle, set round=0, cnt=0, zeta_old=0, then go to LOAD.
REQ-018 LOAD SHALL assert rnd_ready and wait for rnd_valid; on the handshake (rnd_valid & rnd_ready), zeta_old<=zeta_new (0 in layer 0), zeta_new<=rnd_data, go to RUN.
REQ-019 LOAD in the last layer (round=ROUNDS-1) SHALL skip the handshake: zeta_old<=zeta_new, zeta_new<=0, go to RUN the next cycle, rnd_ready=0.
REQ-020 RUN SHALL drive en=~stall; cnt SHALL increment on each en cycle; stall=1 SHALL hold cnt, round and masks.
REQ-021 RUN with en=1 and cnt=CNT_MAX SHALL wrap cnt to 0; if round<ROUNDS-1, round+1 and go to LOAD; else go to DRAIN.
REQ-022 DRAIN SHALL hold en=0 for exactly PIPE_DEPTH cycles while holding masks stable, then go to FIN.
REQ-023 FIN SHALL pulse done for 1 cycle and return to IDLE; round and cnt SHALL hold their final values until the next CLR.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 start asserted while busy SHALL be ignored and SHALL NOT be queued.
REQ-026 Total latency from start to done, with no stall and rnd_valid tied high, SHALL be 1 (CLR) + 4x(1 LOAD + 64 RUN) + PIPE_DEPTH + 1 = 267 cycles.
REQ-027 en SHALL never be asserted outside RUN; rnd_ready SHALL never be asserted outside LOAD.
REQ-028 All outputs SHALL be registered, except en, which is decoded from state and stall.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE, clear every output and register to 0, and set mode=0.
REQ-030 A reset mid-transform SHALL abandon it: no done pulse, and the next start restarts from CLR.

Structure
REQ-031 Mode codes, state encoding, N2=512, PIPE_DEPTH, CNT_MAX and ROUNDS SHALL live in shared package ntt_pkg.
REQ-032 The block SHALL be a single flat FSM plus counters with no sub-module; the address unit is instantiated by the parent, not by this block.

Verification
REQ-033 Forward, start=1, mode_in=0, rnd_valid=1 always, no stall -> done at cycle 267 after start, exactly 256 en cycles, rnd_ready handshakes=3.
REQ-034 rnd_data=0x055,0x1A0,0x0F3 in layers 0-2 -> (zeta_new,zeta_old) per layer = (0x055,0),(0x1A0,0x055),(0x0F3,0x1A0),(0,0x0F3).
REQ-035 stall=1 for 10 cycles at cnt=30 in layer 2 -> cnt holds 30, en=0, done is delayed by exactly 10 cycles.
REQ-036 rnd_valid withheld 7 cycles in layer 1 LOAD -> rnd_ready stays high, en=0, done is delayed by 7 cycles.
REQ-037 mode_in=3 with start -> err pulses 1 cycle, busy stays 0; start pulsed at cycle 100 of a run -> no effect on counters or done.
REQ-038 rst=0 asserted in RUN layer 2 -> all outputs 0 asynchronously, no done; a following start completes normally.

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared constants, mode codes and controller state encoding for the NTT datapath.
// Imported by the round controller and its bus interface.
package ntt_pkg;

    localparam int N2         = 512;
    localparam int PIPE_DEPTH = 5;
    localparam int CNT_MAX    = 63;
    localparam int ROUNDS     = 4;

    localparam int MODE_W = 3;
    localparam int MASK_W = $clog2(N2);
    localparam int CNT_W  = 6;
    localparam int RND_W  = 2;

    localparam logic [MODE_W-1:0] MODE_FWD = 3'd0;
    localparam logic [MODE_W-1:0] MODE_INV = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_LOAD  = 3'd2,
        S_RUN   = 3'd3,
        S_DRAIN = 3'd4,
        S_FIN   = 3'd5
    } state_e;

    function automatic logic mode_legal(input logic [MODE_W-1:0] m);
        return (m == MODE_FWD) || (m == MODE_INV);
    endfunction

endpackage

// File: rtl/ntt_round_ctrl_if.sv
// Host-side bus of the NTT round controller: command, back-pressure, mask source and status.
// The parent drives through master; the controller sits on slave.
interface ntt_round_ctrl_if;
    import ntt_pkg::*;

    logic              start;
    logic [MODE_W-1:0] mode_in;
    logic              stall;
    logic              rnd_valid;
    logic [MASK_W-1:0] rnd_data;
    logic              rnd_ready;
    logic [MODE_W-1:0] mode;
    logic              addr_rst;
    logic              en;
    logic [MASK_W-1:0] zeta_new;
    logic [MASK_W-1:0] zeta_old;
    logic [RND_W-1:0]  round;
    logic [CNT_W-1:0]  cnt;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, mode_in, stall, rnd_valid, rnd_data,
        input  rnd_ready, mode, addr_rst, en, zeta_new, zeta_old,
               round, cnt, busy, done, err
    );

    modport slave (
        input  start, mode_in, stall, rnd_valid, rnd_data,
        output rnd_ready, mode, addr_rst, en, zeta_new, zeta_old,
               round, cnt, busy, done, err
    );

endinterface

// File: rtl/ntt_round_ctrl.sv
// Layer sequencer for a masked NTT: clears the address unit, fetches one mask per layer,
// steps the butterfly counter under back-pressure, drains the address pipeline, then signals done.
module ntt_round_ctrl #(
    parameter int PIPE_DEPTH = ntt_pkg::PIPE_DEPTH,
    parameter int CNT_MAX    = ntt_pkg::CNT_MAX,
    parameter int ROUNDS     = ntt_pkg::ROUNDS
) (
    input logic             clk,
    input logic             rst,
    ntt_round_ctrl_if.slave bus
);
    import ntt_pkg::*;

    localparam int DRAIN_W = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(CNT_MAX);
    localparam logic [RND_W-1:0]   ROUND_LAST = RND_W'(ROUNDS - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(PIPE_DEPTH - 1);

    state_e             state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [RND_W-1:0]   round_q, round_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [MASK_W-1:0]  zn_q, zn_d;
    logic [MASK_W-1:0]  zo_q, zo_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               err_d;
    logic               addr_rst_q, rnd_ready_q, busy_q, done_q, err_q;

    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        zn_d    = zn_q;
        zo_d    = zo_q;
        drain_d = drain_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (mode_legal(bus.mode_in)) begin
                        mode_d  = bus.mode_in;
                        state_d = S_CLR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_CLR: begin
                round_d = '0;
                cnt_d   = '0;
                zn_d    = '0;
                zo_d    = '0;
                state_d = S_LOAD;
            end

            // The last layer has no fresh mask: it only retires the previous one.
            S_LOAD: begin
                if (round_q == ROUND_LAST) begin
                    zo_d    = zn_q;
                    zn_d    = '0;
                    state_d = S_RUN;
                end else if (bus.rnd_valid && rnd_ready_q) begin
                    zo_d    = zn_q;
                    zn_d    = bus.rnd_data;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                if (!bus.stall) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (round_q == ROUND_LAST) begin
                            drain_d = '0;
                            state_d = S_DRAIN;
                        end else begin
                            round_d = round_q + RND_W'(1);
                            state_d = S_LOAD;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end

            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_FIN;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end

            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Status strobes are registered from the next state so they line up with the state they describe.
    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            mode_q      <= '0;
            round_q     <= '0;
            cnt_q       <= '0;
            zn_q        <= '0;
            zo_q        <= '0;
            drain_q     <= '0;
            addr_rst_q  <= 1'b0;
            rnd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            round_q     <= round_d;
            cnt_q       <= cnt_d;
            zn_q        <= zn_d;
            zo_q        <= zo_d;
            drain_q     <= drain_d;
            addr_rst_q  <= (state_d == S_CLR);
            rnd_ready_q <= (state_d == S_LOAD) && (round_d != ROUND_LAST);
            busy_q      <= (state_d != S_IDLE);
            done_q      <= (state_d == S_FIN);
            err_q       <= err_d;
        end
    end

    // en is the only combinational output: the address unit must freeze in the same cycle as stall.
    assign bus.en        = (state_q == S_RUN) && !bus.stall;
    assign bus.rnd_ready = rnd_ready_q;
    assign bus.mode      = mode_q;
    assign bus.addr_rst  = addr_rst_q;
    assign bus.zeta_new  = zn_q;
    assign bus.zeta_old  = zo_q;
    assign bus.round     = round_q;
    assign bus.cnt       = cnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule
